// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: state encoding and default timing.
package btn_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE      = 2'd0;
    localparam btn_state_t PRESS_CHK = 2'd1;
    localparam btn_state_t HELD      = 2'd2;
    localparam btn_state_t REL_CHK   = 2'd3;

    // Defaults sized for a 50 MHz sys_clk: 10 ms debounce, 2 s long press.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_CNT_W           = 20;
    localparam int unsigned DEF_LONG_CYCLES     = 100000000;
    localparam int unsigned DEF_LONG_W          = 27;

    // True in the states where the button is considered pressed.
    function automatic logic is_held(input btn_state_t s);
        return (s == HELD) || (s == REL_CHK);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit pad input.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Capture the pad and give the first flop a cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, counter debounce FSM, one-cycle press pulse
// and a debounced level. Define BUTTON_CONDITIONER_LONGPRESS_EN to add the long-press pulse.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned LONG_W          = DEF_LONG_W
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic button_raw,
    output logic trigger_out,
    output logic btn_level,
    output logic long_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             raw_sync;
    logic             act_c;
    btn_state_t       state_q;
    btn_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             trigger_d;
    logic             level_d;

    // Synchronise in raw polarity so reset loads the released level.
    sync_2ff #(
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .d     (button_raw),
        .q     (raw_sync)
    );

    // Normalise to 1 = pressed after the synchroniser.
    assign act_c = raw_sync ^ BTN_ACTIVE_LOW;

    // State, counter and registered outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            trigger_out <= 1'b0;
            btn_level   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trigger_out <= trigger_d;
            btn_level   <= level_d;
        end
    end

    // Next state and stability counter; counter clears on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (act_c) state_d = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!act_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!act_c) state_d = REL_CHK;
            end
            REL_CHK: begin
                if (act_c) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: pulse on press acceptance, level follows the held states.
    always_comb begin
        trigger_d = 1'b0;
        level_d   = 1'b0;
        if ((state_q == PRESS_CHK) && act_c && (cnt_q == CNT_LAST)) trigger_d = 1'b1;
        level_d = is_held(state_d);
    end

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_cnt_q;

    // Hold-time counter; saturates one past the trigger value so it fires once per hold.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            long_cnt_q <= '0;
            long_press <= 1'b0;
        end else if (is_held(state_q)) begin
            if (long_cnt_q != LONG_SAT) long_cnt_q <= long_cnt_q + LONG_W'(1);
            long_press <= (long_cnt_q == LONG_LAST);
        end else begin
            long_cnt_q <= '0;
            long_press <= 1'b0;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low button.
module tb_button_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic reset_n;
    logic button_raw;
    logic trigger_out;
    logic btn_level;
    logic long_press;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int unsigned exp_trig[$];
    int unsigned exp_long[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3),
        .BTN_ACTIVE_LOW  (1'b1),
        .LONG_CYCLES     (LONG),
        .LONG_W          (5)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .button_raw  (button_raw),
        .trigger_out (trigger_out),
        .btn_level   (btn_level),
        .long_press  (long_press)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Press the button now; trigger is due DEB+2 edges after the first sampling edge.
    task automatic start_press(output int unsigned base);
        button_raw = 1'b0;
        base = cyc;
        exp_trig.push_back(base + DEB + 3);
    endtask

    // Long press is due LONG edges after HELD entry, only when the feature is built.
    task automatic expect_long(input int unsigned base);
        if (LP_EN) exp_long.push_back(base + DEB + 3 + LONG);
    endtask

    // Release and check the level drops exactly DEB+2 edges after the first released sample.
    task automatic release_and_check();
        button_raw = 1'b1;
        tick(DEB + 2);
        check("release_level_still_high", btn_level, 1);
        tick(1);
        check("release_level_drop", btn_level, 0);
        tick(3);
    endtask

    // Monitor: every output pulse must match the head of its expectation queue.
    always @(negedge sys_clk) begin
        int unsigned e;
        if (trigger_out) begin
            if (exp_trig.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_trigger: trigger_out=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_trig.pop_front();
                check("trigger_cycle", cyc, e);
                check("level_at_trigger", btn_level, 1);
            end
        end
        if (long_press) begin
            if (exp_long.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_long_press: long_press=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_long.pop_front();
                check("long_press_cycle", cyc, e);
            end
        end
    end

    initial begin
        int unsigned b;
        reset_n    = 1'b0;
        button_raw = 1'b1;
        tick(3);
        check("reset_trigger", trigger_out, 0);
        check("reset_level", btn_level, 0);
        check("reset_long", long_press, 0);
        reset_n = 1'b1;
        tick(4);

        // Clean press held 30 cycles.
        start_press(b);
        expect_long(b);
        tick(DEB + 2);
        check("clean_level_before_accept", btn_level, 0);
        tick(30 - (DEB + 2));
        release_and_check();

        // Bounce: toggle every 2 cycles for 12 cycles, then steady pressed.
        for (int i = 0; i < 6; i++) begin
            button_raw = (i % 2 == 1);
            tick(2);
        end
        check("bounce_level_low", btn_level, 0);
        start_press(b);
        tick(15);
        release_and_check();

        // Release bounce: brief release from HELD must not leave HELD or retrigger.
        start_press(b);
        expect_long(b);
        tick(10);
        button_raw = 1'b1;
        tick(2);
        button_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("release_bounce_level", btn_level, 1);
            tick(1);
        end
        tick(12);
        release_and_check();

        // Reset while in PRESS_CHK with cnt=2; the aborted press must not pulse.
        button_raw = 1'b0;
        b = cyc;
        tick(5);
        reset_n = 1'b0;
        #1;
        check("reset_mid_trigger", trigger_out, 0);
        check("reset_mid_level", btn_level, 0);
        check("reset_mid_long", long_press, 0);
        tick(2);
        reset_n = 1'b1;
        b = cyc;
        exp_trig.push_back(b + DEB + 3);
        tick(15);
        release_and_check();

        // Reset while HELD clears the level asynchronously.
        start_press(b);
        tick(10);
        check("held_level_before_reset", btn_level, 1);
        button_raw = 1'b1;
        reset_n = 1'b0;
        #1;
        check("reset_held_level", btn_level, 0);
        check("reset_held_trigger", trigger_out, 0);
        tick(2);
        reset_n = 1'b1;
        tick(10);

        // Long hold of 40 cycles.
        start_press(b);
        expect_long(b);
        tick(DEB + 3 + LONG);
        check("long_press_at_due_cycle", long_press, LP_EN ? 1 : 0);
        tick(40 - (DEB + 3 + LONG));
        release_and_check();

        tick(5);
        check("trigger_queue_drained", exp_trig.size(), 0);
        check("long_queue_drained", exp_long.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions a raw mechanical start/stop push-button before it reaches the stopwatch top's trigger_in.
- Sequence: 2-flop synchroniser, then counter-based debounce FSM, then a single-cycle press pulse.
- trigger_out connects directly to the stopwatch's trigger input.
- Also provides a clean debounced level and, optionally, a long-press pulse for a future reset-by-hold function.

Parameters:
- DEBOUNCE_CYCLES, 500000, sys_clk cycles the input must stay stable to be accepted (10 ms at 50 MHz); legal range >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1, 1 = button_raw low means pressed; 0 = high means pressed.
- LONG_CYCLES, 100000000, hold duration for long_press (2 s at 50 MHz); used only with the optional feature.
- LONG_W, 27, long-press counter width.

Ports:
- sys_clk  input  1  system clock, single clock domain.
- reset_n  input  1  asynchronous active-low reset.
- button_raw  input  1  asynchronous, bouncing pad input.
- trigger_out  output  1  one-cycle pulse per accepted press.
- btn_level  output  1  debounced level, 1 = pressed.
- long_press  output  1  one-cycle pulse per hold exceeding LONG_CYCLES.

Behaviour:
- Reset (asynchronous, reset_n low): sync flops = released level, state = IDLE, counters = 0, trigger_out = 0, btn_level = 0, long_press = 0. Reset mid-press aborts; no pulse is emitted on reset release.
- Synchroniser: two flops; the active-level normalisation from BTN_ACTIVE_LOW is applied after the flops, giving act (1 = pressed).
- FSM states (encoding in package): IDLE, PRESS_CHK, HELD, REL_CHK.
- IDLE: act=1 -> PRESS_CHK, cnt=0.
- PRESS_CHK:
  - act=0 -> IDLE (bounce rejected).
  - else if cnt==DEBOUNCE_CYCLES-1 -> HELD, trigger_out=1 for the next cycle only.
  - else cnt+1.
- HELD: act=0 -> REL_CHK, cnt=0.
- REL_CHK:
  - act=1 -> HELD (no new trigger).
  - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - else cnt+1.
- btn_level = 1 in HELD and REL_CHK, 0 in IDLE and PRESS_CHK; it is registered and rises on the same edge as trigger_out.
- Latency: with edge 0 the first edge sampling a stable pressed raw level, trigger_out is high after edge DEBOUNCE_CYCLES+2 for exactly one cycle. Release is accepted DEBOUNCE_CYCLES+2 edges after the first stable released sample.
- Counter never wraps; it is compared against DEBOUNCE_CYCLES-1 and cleared on every state entry.
- At most one trigger_out per press, regardless of bounce count or hold length. A new trigger requires a full return to IDLE first.
- All outputs are registered; there are no combinational paths from button_raw.

Optional Feature:
- Macro: BUTTON_CONDITIONER_LONGPRESS_EN.
- Defined:
  - A LONG_W counter runs while in HELD or REL_CHK and clears in IDLE.
  - When it equals LONG_CYCLES-1, long_press pulses for one cycle.
  - The counter then saturates, so there is one pulse per hold.
  - A bounce during release (REL_CHK -> HELD) does not restart the count.
- Undefined: long_press is tied to 0 and the long counter is not instantiated.
- Port list is identical in both cases.

Decomposition:
- Shared package btn_pkg: state encoding localparams (IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, REL_CHK=2'd3) and default timing constants.
- One sub-module: sync_2ff (parameterised reset value, async active-low reset). It is reused later for other pad inputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BTN_ACTIVE_LOW=1):
- Clean press: button_raw 1->0 held 30 cycles -> trigger_out high only in the cycle after edge 6; btn_level=1 from that edge; exactly one pulse.
- Bounce: raw toggles 0/1 every 2 cycles for 12 cycles, then steady 0 -> no pulse during toggling; a single trigger_out 6 edges after steady 0 begins.
- Release bounce: from HELD, raw goes 1 for 2 cycles then back to 0 -> stays HELD; btn_level stays 1; no second trigger.
- Reset mid-operation: assert reset_n=0 while in PRESS_CHK at cnt=2 -> all outputs 0 immediately (asynchronous); after release with raw still pressed, trigger_out occurs 6 edges after the first post-reset sample.
- Long press (macro defined): hold 40 cycles -> trigger_out once, long_press once, 20 cycles after HELD entry. Macro undefined -> long_press stays 0 throughout.
